uart_boot_sequencer: RTL and testbench
======================================

Name: uart_boot_sequencer

Overview:
- AXI4-Lite master that drives the UART peripheral's register map to download a program image into memory at power-up.
- Polls the RX byte count and pops 64-bit words once at least 8 bytes are buffered.
- The first word is a length header; each following word is written to memory through a second AXI4-Lite master port.
- Holds the CPU in reset until the image is fully loaded, then releases it.

Parameters:
- UART_BASE, 32'h0000_0000, base address of the UART register block (0x00 RX count, 0x08 RX pop).
- LOAD_BASE, 32'h0000_0000, memory address of image word 0.
- MAX_WORDS, 4096, largest accepted header value (64-bit words).
- POLL_GAP, 64, idle cycles between RX-count polls when fewer than 8 bytes are available.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level; sequence begins on first cycle seen high in IDLE
- u_araddr  out  32  UART read address
- u_arvalid  out  1  UART read address valid
- u_arready  in  1  UART read address ready
- u_rdata  in  64  UART read data
- u_rvalid  in  1  UART read data valid
- u_rready  out  1  UART read data ready
- m_awaddr  out  32  memory write address
- m_awvalid  out  1  memory write address valid
- m_awready  in  1  memory write address ready
- m_wdata  out  64  memory write data
- m_wstrb  out  8  memory write strobes, constant 8'hFF
- m_wvalid  out  1  memory write data valid
- m_wready  in  1  memory write data ready
- m_bresp  in  2  memory write response
- m_bvalid  in  1  memory write response valid
- m_bready  out  1  memory write response ready
- cpu_rst  out  1  high holds the CPU in reset
- busy  out  1  sequence in progress
- done  out  1  image loaded; sticky until rst
- error  out  1  load aborted; sticky until rst
- words_loaded  out  32  memory writes completed

Behaviour:
- Reset values: all valid/ready outputs 0; cpu_rst=1; busy=0; done=0; error=0; words_loaded=0; state IDLE; addresses 0.
- States:
  - IDLE: on start go to POLL_AR.
  - POLL_AR: u_araddr=UART_BASE+0x00, u_arvalid=1 until u_arready, then POLL_R.
  - POLL_R: u_rready=1; on u_rvalid, if rdata>=8 go to POP_AR, else load gap counter with POLL_GAP and go to WAIT.
  - WAIT: count down to 0, then POLL_AR.
  - POP_AR: address UART_BASE+0x08; same handshake as POLL_AR, then POP_R.
  - POP_R: u_rready=1; on u_rvalid, capture rdata.
    - Header phase: 0 goes to DONE; value >MAX_WORDS goes to ERROR; otherwise latch remaining=value and go to POLL_AR.
    - Payload phase: go to MEM_WR.
  - MEM_WR: m_awvalid and m_wvalid both rise on entry; each drops independently on its own handshake (aw and w may complete in either order or the same cycle). Leave when both are done, go to MEM_B.
  - MEM_B: m_bready=1. On m_bvalid:
    - bresp!=0 goes to ERROR.
    - Otherwise words_loaded+1, remaining-1; go to DONE if remaining reaches 0, else POLL_AR.
  - DONE: done=1, cpu_rst=0, busy=0; terminal until rst.
  - ERROR: error=1, cpu_rst stays 1, busy=0; terminal until rst.
- busy=1 in every state except IDLE, DONE and ERROR.
- m_awaddr = LOAD_BASE + 8*words_loaded (32-bit wrapping add).
- u_araddr, m_awaddr and m_wdata are stable while the corresponding valid is high.
- Words are popped only when RX count>=8, so the UART pop clamp never truncates a word.
- u_rdata is used as-is; rresp is not checked.
- u_arvalid is never raised while a UART read is outstanding: one transaction in flight per port.
- Header compare uses the full 64 bits. Values >=2^32 count as >MAX_WORDS.
- start deasserting mid-sequence has no effect; a second start after DONE/ERROR is ignored.
- rst mid-transaction returns everything to reset values in the next cycle, including dropping valids.

Test Plan:
- start; UART returns count 16, header word 2, payload 64'h1111_2222_3333_4444 and 64'hAAAA_BBBB_CCCC_DDDD, memory always ready -> writes to LOAD_BASE+0 and +8 with those data, words_loaded=2, done=1, cpu_rst=0.
- Count reads 3, 3, then 8 -> POP issued only after the third poll; POLL_GAP idle cycles between polls; no pop address seen earlier.
- Header 0 -> no memory writes, done=1 the cycle after POP_R completes.
- Header MAX_WORDS+1 -> error=1, cpu_rst=1, no memory transaction.
- Memory w accepted 3 cycles before aw; then bresp=2'b10 on the first word -> awvalid/wvalid each drop on their own handshake, then error=1, words_loaded=0.
- rst asserted while u_arvalid=1 stalled -> next cycle all outputs at reset values; a new start then reruns the full sequence correctly.

Source files
------------

// File: rtl/uart_boot_sequencer.sv
// Boot loader: polls the UART RX FIFO over AXI4-Lite, reads a length header and
// copies that many 64-bit words into memory, holding the CPU in reset until finished.
module uart_boot_sequencer #(
    parameter logic [31:0] UART_BASE = 32'h0000_0000,
    parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096,
    parameter int          POLL_GAP  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] u_araddr,
    output logic        u_arvalid,
    input  logic        u_arready,
    input  logic [63:0] u_rdata,
    input  logic        u_rvalid,
    output logic        u_rready,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [63:0] m_wdata,
    output logic [7:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] words_loaded
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL_AR,
        S_POLL_R,
        S_WAIT,
        S_POP_AR,
        S_POP_R,
        S_MEM_WR,
        S_MEM_B,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, state_next;
    logic [31:0] gap_cnt, gap_next;
    logic [31:0] remaining, rem_next;
    logic        header_phase, hdr_next;
    logic [63:0] wdata_q, wdata_next;
    logic        aw_done, aw_done_next;
    logic        w_done, w_done_next;
    logic [31:0] loaded_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            gap_cnt      <= '0;
            remaining    <= '0;
            header_phase <= 1'b1;
            wdata_q      <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_next;
            gap_cnt      <= gap_next;
            remaining    <= rem_next;
            header_phase <= hdr_next;
            wdata_q      <= wdata_next;
            aw_done      <= aw_done_next;
            w_done       <= w_done_next;
            words_loaded <= loaded_next;
        end
    end

    // A word is popped only once the FIFO holds a full 8 bytes, so no pop is ever short.
    always_comb begin
        state_next   = state;
        gap_next     = gap_cnt;
        rem_next     = remaining;
        hdr_next     = header_phase;
        wdata_next   = wdata_q;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        loaded_next  = words_loaded;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_POLL_AR;
                    hdr_next   = 1'b1;
                end
            end
            S_POLL_AR: begin
                if (u_arready) state_next = S_POLL_R;
            end
            S_POLL_R: begin
                if (u_rvalid) begin
                    if (u_rdata >= 64'd8) begin
                        state_next = S_POP_AR;
                    end else begin
                        gap_next   = 32'(POLL_GAP);
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (gap_cnt <= 32'd1) state_next = S_POLL_AR;
                else gap_next = gap_cnt - 32'd1;
            end
            S_POP_AR: begin
                if (u_arready) state_next = S_POP_R;
            end
            S_POP_R: begin
                if (u_rvalid) begin
                    if (header_phase) begin
                        if (u_rdata == 64'd0) begin
                            state_next = S_DONE;
                        end else if (u_rdata > 64'(MAX_WORDS)) begin
                            state_next = S_ERROR;
                        end else begin
                            rem_next   = u_rdata[31:0];
                            hdr_next   = 1'b0;
                            state_next = S_POLL_AR;
                        end
                    end else begin
                        wdata_next   = u_rdata;
                        aw_done_next = 1'b0;
                        w_done_next  = 1'b0;
                        state_next   = S_MEM_WR;
                    end
                end
            end
            S_MEM_WR: begin
                aw_done_next = aw_done | m_awready;
                w_done_next  = w_done | m_wready;
                if (aw_done_next && w_done_next) state_next = S_MEM_B;
            end
            S_MEM_B: begin
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) begin
                        state_next = S_ERROR;
                    end else begin
                        loaded_next = words_loaded + 32'd1;
                        rem_next    = remaining - 32'd1;
                        state_next  = (remaining == 32'd1) ? S_DONE : S_POLL_AR;
                    end
                end
            end
            default: state_next = state;
        endcase
    end

    // Address and data come from registered state, so they hold steady while valid is up.
    assign u_araddr  = (state == S_POP_AR)  ? UART_BASE + 32'h8 :
                       (state == S_POLL_AR) ? UART_BASE : 32'h0;
    assign u_arvalid = (state == S_POLL_AR) || (state == S_POP_AR);
    assign u_rready  = (state == S_POLL_R) || (state == S_POP_R);
    assign m_awaddr  = LOAD_BASE + {words_loaded[28:0], 3'b000};
    assign m_awvalid = (state == S_MEM_WR) && !aw_done;
    assign m_wvalid  = (state == S_MEM_WR) && !w_done;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = 8'hFF;
    assign m_bready  = (state == S_MEM_B);
    assign cpu_rst   = (state != S_DONE);
    assign busy      = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Directed bench for uart_boot_sequencer: the bench plays the UART and the memory
// slave and checks every handshake against hand-computed values.
module tb_uart_boot_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] u_araddr;
    logic        u_arvalid;
    logic        u_arready;
    logic [63:0] u_rdata;
    logic        u_rvalid;
    logic        u_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] words_loaded;

    int total  = 0;
    int passed = 0;

    uart_boot_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .u_araddr(u_araddr), .u_arvalid(u_arvalid), .u_arready(u_arready),
        .u_rdata(u_rdata), .u_rvalid(u_rvalid), .u_rready(u_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        start = 1'b0; u_arready = 1'b0; u_rdata = '0; u_rvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_arvalid"}, u_arvalid, 0);
        check_output({tag, "_rready"}, u_rready, 0);
        check_output({tag, "_awvalid"}, m_awvalid, 0);
        check_output({tag, "_wvalid"}, m_wvalid, 0);
        check_output({tag, "_bready"}, m_bready, 0);
        check_output({tag, "_cpu_rst"}, cpu_rst, 1);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_error"}, error, 0);
        check_output({tag, "_words"}, words_loaded, 0);
        check_output({tag, "_araddr"}, u_araddr, 0);
        check_output({tag, "_awaddr"}, m_awaddr, 0);
    endtask

    task automatic apply_reset(input string tag);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        check_reset_state(tag);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_arvalid(input string tag);
        int n = 0;
        while (!u_arvalid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!u_arvalid) check_output({tag, "_ar_timeout"}, 0, 1);
    endtask

    task automatic uart_read(input string tag, input logic [31:0] exp_addr, input logic [63:0] data);
        wait_arvalid(tag);
        check_output({tag, "_araddr"}, u_araddr, exp_addr);
        u_arready = 1'b1;
        @(negedge clk);
        u_arready = 1'b0;
        u_rvalid  = 1'b1;
        u_rdata   = data;
        check_output({tag, "_rready"}, u_rready, 1);
        @(negedge clk);
        u_rvalid = 1'b0;
        u_rdata  = '0;
    endtask

    task automatic mem_write(input string tag, input logic [31:0] exp_addr, input logic [63:0] exp_data,
                             input int aw_delay, input int w_delay, input logic [1:0] resp);
        int  n = 0;
        int  c = 0;
        bit  aw_got = 0;
        bit  w_got = 0;
        while (!m_awvalid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!m_awvalid) check_output({tag, "_aw_timeout"}, 0, 1);
        check_output({tag, "_awaddr"}, m_awaddr, exp_addr);
        check_output({tag, "_wdata"}, m_wdata, exp_data);
        check_output({tag, "_wstrb"}, m_wstrb, 8'hFF);
        while ((!aw_got || !w_got) && c < 100) begin
            check_output({tag, "_awvalid"}, m_awvalid, !aw_got);
            check_output({tag, "_wvalid"}, m_wvalid, !w_got);
            m_awready = (c >= aw_delay) && !aw_got;
            m_wready  = (c >= w_delay) && !w_got;
            @(posedge clk);
            if (m_awready) aw_got = 1;
            if (m_wready) w_got = 1;
            @(negedge clk);
            m_awready = 1'b0;
            m_wready  = 1'b0;
            c++;
        end
        check_output({tag, "_awvalid_off"}, m_awvalid, 0);
        check_output({tag, "_wvalid_off"}, m_wvalid, 0);
        check_output({tag, "_bready"}, m_bready, 1);
        m_bvalid = 1'b1;
        m_bresp  = resp;
        @(negedge clk);
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
    endtask

    task automatic run_good_image(input string tag);
        start = 1'b1;
        uart_read({tag, "_poll0"}, 32'h0, 64'd16);
        uart_read({tag, "_hdr"}, 32'h8, 64'd2);
        uart_read({tag, "_poll1"}, 32'h0, 64'd16);
        uart_read({tag, "_pop1"}, 32'h8, 64'h1111_2222_3333_4444);
        mem_write({tag, "_wr0"}, 32'h0, 64'h1111_2222_3333_4444, 0, 0, 2'b00);
        check_output({tag, "_words_mid"}, words_loaded, 1);
        check_output({tag, "_busy_mid"}, busy, 1);
        uart_read({tag, "_poll2"}, 32'h0, 64'd8);
        uart_read({tag, "_pop2"}, 32'h8, 64'hAAAA_BBBB_CCCC_DDDD);
        mem_write({tag, "_wr1"}, 32'h8, 64'hAAAA_BBBB_CCCC_DDDD, 1, 1, 2'b00);
        check_output({tag, "_done"}, done, 1);
        check_output({tag, "_cpu_rst"}, cpu_rst, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_error"}, error, 0);
        check_output({tag, "_words"}, words_loaded, 2);
    endtask

    task automatic measure_gap(input string tag, input int exp_gap);
        int n = 0;
        while (!u_arvalid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_gap"}, n, exp_gap);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;
        @(negedge clk);

        // Normal two-word image, then a repeated start must be ignored.
        run_good_image("img");
        start = 1'b1;
        repeat (5) @(negedge clk);
        check_output("restart_arvalid", u_arvalid, 0);
        check_output("restart_done", done, 1);

        // Low RX counts make the loader back off before popping.
        apply_reset("rst_a");
        start = 1'b1;
        uart_read("lowcnt0", 32'h0, 64'd3);
        measure_gap("lowcnt0", 64);
        uart_read("lowcnt1", 32'h0, 64'd3);
        measure_gap("lowcnt1", 64);
        uart_read("lowcnt2", 32'h0, 64'd8);
        uart_read("hdr0", 32'h8, 64'd0);
        check_output("hdr0_done", done, 1);
        check_output("hdr0_awvalid", m_awvalid, 0);
        check_output("hdr0_words", words_loaded, 0);

        // Oversize header aborts without touching memory.
        apply_reset("rst_b");
        start = 1'b1;
        uart_read("big_poll", 32'h0, 64'd8);
        uart_read("big_hdr", 32'h8, 64'd4097);
        check_output("big_error", error, 1);
        check_output("big_cpu_rst", cpu_rst, 1);
        check_output("big_busy", busy, 0);
        check_output("big_awvalid", m_awvalid, 0);

        // Header above 32 bits must not be truncated into a small count.
        apply_reset("rst_c");
        start = 1'b1;
        uart_read("wide_poll", 32'h0, 64'd8);
        uart_read("wide_hdr", 32'h8, 64'h1_0000_0001);
        check_output("wide_error", error, 1);

        // Header exactly MAX_WORDS is accepted and polling continues.
        apply_reset("rst_d");
        start = 1'b1;
        uart_read("max_poll", 32'h0, 64'd8);
        uart_read("max_hdr", 32'h8, 64'd4096);
        check_output("max_error", error, 0);
        check_output("max_busy", busy, 1);
        uart_read("max_poll2", 32'h0, 64'd2);

        // W accepted three cycles ahead of AW, then an error response.
        apply_reset("rst_e");
        start = 1'b1;
        uart_read("bresp_poll", 32'h0, 64'd8);
        uart_read("bresp_hdr", 32'h8, 64'd1);
        uart_read("bresp_poll2", 32'h0, 64'd8);
        uart_read("bresp_pop", 32'h8, 64'h0123_4567_89AB_CDEF);
        mem_write("bresp_wr", 32'h0, 64'h0123_4567_89AB_CDEF, 3, 0, 2'b10);
        check_output("bresp_error", error, 1);
        check_output("bresp_cpu_rst", cpu_rst, 1);
        check_output("bresp_words", words_loaded, 0);
        check_output("bresp_done", done, 0);

        // Reset while an address request is stalled, then a clean rerun.
        apply_reset("rst_f");
        start = 1'b1;
        wait_arvalid("stall");
        repeat (3) @(negedge clk);
        check_output("stall_arvalid", u_arvalid, 1);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        @(negedge clk);
        run_good_image("rerun");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
